// File: rtl/flex_counter_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flex_counter_multi                                            |
// | Purpose  : NUM_CHANNELS independent flexible counters. Each channel has   |
// |            a programmable terminal value, up/down counting, wrap or      |
// |            saturate mode, synchronous clear and parallel load.           |
// |            Each channel reports a registered terminal-count level and a  |
// |            one-cycle wrap pulse.                                         |
// | Option   : define FLEX_CNT_CASCADE_EN to chain the channels into a       |
// |            ripple prescaler. Channel i>0 then counts only on the edges   |
// |            where channel i-1 wraps.                                      |
// | Revision : 1.0 - initial multi-channel release                           |
// +--------------------------------------------------------------------------+
module flex_counter_multi #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [NUM_CHANNELS-1:0]              clear,
  input  logic [NUM_CHANNELS-1:0]              load,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CHANNELS-1:0]              count_enable,
  input  logic [NUM_CHANNELS-1:0]              count_down,
  input  logic [NUM_CHANNELS-1:0]              saturate,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CHANNELS-1:0]              at_terminal,
  output logic [NUM_CHANNELS-1:0]              wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] c_one = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_cnt      [NUM_CHANNELS];
  logic [NUM_CNT_BITS-1:0] w_next_cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_term;
  logic [NUM_CHANNELS-1:0] r_wrap;
  logic [NUM_CHANNELS-1:0] w_next_term;
  logic [NUM_CHANNELS-1:0] w_next_wrap;

  // Next-state count, wrap and terminal flags for every channel (priority clear > load > count > hold)
  always_comb begin : p_next
    logic [NUM_CNT_BITS-1:0] cur;
    logic [NUM_CNT_BITS-1:0] rv;
    logic                    en;
`ifdef FLEX_CNT_CASCADE_EN
    // Same-edge wrap of the previous channel; carried down the loop so no
    // signal feeds back into itself.
    logic                    prev_wrap;
    prev_wrap = 1'b0;
`endif
    cur = '0;
    rv  = '0;
    en  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cur            = r_cnt[i];
      rv             = rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      en             = count_enable[i];
      w_next_cnt[i]  = cur;
      w_next_wrap[i] = 1'b0;
`ifdef FLEX_CNT_CASCADE_EN
      if (i != 0) begin
        en = en & prev_wrap;
      end
`endif
      if (clear[i]) begin
        w_next_cnt[i] = '0;
      end else if (load[i]) begin
        w_next_cnt[i] = load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      end else if (en) begin
        if (count_down[i]) begin
          // A count above rollover_val is legal here and just decrements.
          if (cur == '0) begin
            if (!saturate[i]) begin
              w_next_cnt[i]  = rv;
              w_next_wrap[i] = 1'b1;
            end
          end else begin
            w_next_cnt[i] = cur - c_one;
          end
        end else begin
          // ">=" folds an out-of-range count (after load or a lowered
          // rollover_val) back into range instead of running to 2^N.
          if (cur >= rv) begin
            if (!saturate[i]) begin
              w_next_cnt[i]  = '0;
              w_next_wrap[i] = 1'b1;
            end
          end else begin
            w_next_cnt[i] = cur + c_one;
          end
        end
      end
      // Terminal flag follows the next count, so it also tracks
      // rollover_val/count_down changes during hold cycles.
      if (clear[i]) begin
        w_next_term[i] = 1'b0;
      end else if (count_down[i]) begin
        w_next_term[i] = (w_next_cnt[i] == '0);
      end else begin
        w_next_term[i] = (w_next_cnt[i] == rv);
      end
`ifdef FLEX_CNT_CASCADE_EN
      prev_wrap = w_next_wrap[i];
`endif
    end
  end

  // State registers for all channels, asynchronously cleared
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
      r_term <= '0;
      r_wrap <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_cnt[i] <= w_next_cnt[i];
      end
      r_term <= w_next_term;
      r_wrap <= w_next_wrap;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_pack
      assign count_out[g*NUM_CNT_BITS +: NUM_CNT_BITS] = r_cnt[g];
    end
  endgenerate

  assign at_terminal = r_term;
  assign wrap_pulse  = r_wrap;

endmodule
`default_nettype wire
